// File: rtl/fifo_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_reader_pkg
// Brief    : Shared constants for the FIFO-to-stream reader.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_reader_pkg;

    localparam string c_showahead_on  = "ON";
    localparam string c_showahead_off = "OFF";
    localparam int    c_buf_depth     = 2;

endpackage
`default_nettype wire

// File: rtl/skid_buf2.sv
`default_nettype none
// ============================================================================
// Module   : skid_buf2
// Brief    : Two-entry order-preserving output buffer with occupancy output.
// Revision : 1.0 - initial release
// ============================================================================
module skid_buf2
    import fifo_reader_pkg::*;
#(
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DWIDTH-1:0] i_data,
    input  logic              i_pop,
    output logic [DWIDTH-1:0] o_data,
    output logic              o_valid,
    output logic [1:0]        o_occ
);

    logic [DWIDTH-1:0] r_mem     [c_buf_depth];
    logic [1:0]        r_occ;
    logic [DWIDTH-1:0] w_mem_nxt [c_buf_depth];
    logic [1:0]        w_occ_nxt;
    logic [1:0]        w_wr_idx;

    // Entry 0 is always the oldest word; a pop shifts entry 1 down before
    // any incoming word lands in the first free slot.
    always_comb begin
        w_mem_nxt = r_mem;
        if (i_pop) begin
            w_mem_nxt[0] = r_mem[1];
        end
        w_wr_idx = r_occ - {1'b0, i_pop};
        if (i_push) begin
            w_mem_nxt[w_wr_idx[0]] = i_data;
        end
        w_occ_nxt = r_occ + {1'b0, i_push} - {1'b0, i_pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem <= '{default: '0};
            r_occ <= 2'd0;
        end else begin
            r_mem <= w_mem_nxt;
            r_occ <= w_occ_nxt;
        end
    end

    assign o_data  = r_mem[0];
    assign o_valid = (r_occ != 2'd0);
    assign o_occ   = r_occ;

endmodule
`default_nettype wire

// File: rtl/fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_reader
// Brief    : Drains a FIFO read port into a valid/ready stream, counting words.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int    DWIDTH    = 8,
    parameter string SHOWAHEAD = "OFF",
    parameter int    CWIDTH    = 16
) (
    input  logic              clk_i,
    input  logic              srst_i,
    output logic              rd_req_o,
    input  logic [DWIDTH-1:0] q_i,
    input  logic              rd_empty_i,
    output logic [DWIDTH-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CWIDTH-1:0] rd_cnt_o
);

    localparam bit c_showahead = (SHOWAHEAD == c_showahead_on);

    logic              w_rst;
    logic              w_pop;
    logic              w_push;
    logic              w_pend;
    logic              w_rd_req;
    logic [1:0]        w_occ;
    logic [2:0]        w_inflight;
    logic [CWIDTH-1:0] r_cnt;

    assign w_rst = ~srst_i;
    assign w_pop = valid_o & ready_i;

    // Words already owned by the buffer after this cycle's pop; a request is
    // only safe if there will be a free slot when its data arrives.
    assign w_inflight = {1'b0, w_occ} + {2'b0, w_pend} - {2'b0, w_pop};
    assign w_rd_req   = srst_i & ~rd_empty_i & (w_inflight < 3'(c_buf_depth));
    assign rd_req_o   = w_rd_req;

    generate
        if (c_showahead) begin : g_showahead_on
            assign w_pend = 1'b0;
            assign w_push = w_rd_req;
        end else begin : g_showahead_off
            logic r_pend;
            always_ff @(posedge clk_i) begin
                if (!srst_i) begin
                    r_pend <= 1'b0;
                end else begin
                    r_pend <= w_rd_req;
                end
            end
            assign w_pend = r_pend;
            assign w_push = r_pend;
        end
    endgenerate

    skid_buf2 #(
        .DWIDTH (DWIDTH)
    ) u_buf (
        .clk     (clk_i),
        .rst     (w_rst),
        .i_push  (w_push),
        .i_data  (q_i),
        .i_pop   (w_pop),
        .o_data  (data_o),
        .o_valid (valid_o),
        .o_occ   (w_occ)
    );

    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            r_cnt <= '0;
        end else if (w_pop) begin
            r_cnt <= r_cnt + CWIDTH'(1);
        end
    end

    assign rd_cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_reader
// Brief    : Bench for fifo_reader in OFF, ON and narrow-counter configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_reader;

    typedef struct {
        logic [7:0] w;
        int         rc;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       srst   [3];
    logic       ready  [3];
    logic       empty  [3];
    logic       rd_req [3];
    logic       valid  [3];
    logic [7:0] q      [3];
    logic [7:0] data   [3];
    logic [7:0] qreg   [3];
    logic [15:0] cnt0, cnt1, cnt_act;
    logic [3:0]  cnt2;

    logic [7:0] mem [3][64];
    int n    [3] = '{0, 0, 0};
    int head [3] = '{0, 0, 0};

    int   act = 0;
    logic chk_en = 1'b0;
    logic mon_clr = 1'b1;
    int   cyc = 0;
    int   exp_cnt = 0;
    int   total = 0;
    int   bad = 0;
    ent_t mq [$];
    logic [7:0] dlog [$];
    int nreq, freq, fval, rrun, vrun, mrrun, mvrun;

    fifo_reader #(.DWIDTH(8), .SHOWAHEAD("OFF"), .CWIDTH(16)) u_off (
        .clk_i(clk), .srst_i(srst[0]), .rd_req_o(rd_req[0]), .q_i(q[0]),
        .rd_empty_i(empty[0]), .data_o(data[0]), .valid_o(valid[0]),
        .ready_i(ready[0]), .rd_cnt_o(cnt0));

    fifo_reader #(.DWIDTH(8), .SHOWAHEAD("ON"), .CWIDTH(16)) u_on (
        .clk_i(clk), .srst_i(srst[1]), .rd_req_o(rd_req[1]), .q_i(q[1]),
        .rd_empty_i(empty[1]), .data_o(data[1]), .valid_o(valid[1]),
        .ready_i(ready[1]), .rd_cnt_o(cnt1));

    fifo_reader #(.DWIDTH(8), .SHOWAHEAD("OFF"), .CWIDTH(4)) u_c4 (
        .clk_i(clk), .srst_i(srst[2]), .rd_req_o(rd_req[2]), .q_i(q[2]),
        .rd_empty_i(empty[2]), .data_o(data[2]), .valid_o(valid[2]),
        .ready_i(ready[2]), .rd_cnt_o(cnt2));

    // FIFO models: instance 1 is show-ahead, the others registered-output
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rd_req[i]) begin
                head[i] <= head[i] + 1;
                qreg[i] <= mem[i][head[i]];
            end
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_fifo
        assign empty[g] = (head[g] >= n[g]);
        assign q[g]     = (g == 1) ? mem[g][head[g]] : qreg[g];
    end

    always_comb begin
        case (act)
            0:       cnt_act = cnt0;
            1:       cnt_act = cnt1;
            default: cnt_act = {12'b0, cnt2};
        endcase
    end

    // Reference model: each fetched word becomes visible a fixed latency after
    // its request and leaves on valid && ready, in fetch order.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mon_clr) dlog.delete();
        if (!srst[act]) begin
            mq.delete();
            exp_cnt <= 0;
        end else begin
            if (valid[act] && ready[act]) begin
                if (mq.size() > 0) mq.delete(0);
                dlog.push_back(data[act]);
                exp_cnt <= (exp_cnt + 1) & ((act == 2) ? 15 : 65535);
            end
            if (rd_req[act])
                mq.push_back(ent_t'{w: mem[act][head[act]], rc: cyc + ((act == 1) ? 1 : 2)});
        end
    end

    always @(posedge clk) begin
        if (mon_clr) begin
            nreq <= 0; freq <= -1; fval <= -1;
            rrun <= 0; vrun <= 0; mrrun <= 0; mvrun <= 0;
        end else if (srst[act]) begin
            if (rd_req[act]) begin
                nreq <= nreq + 1;
                if (freq < 0) freq <= cyc;
                rrun <= rrun + 1;
                if (rrun + 1 > mrrun) mrrun <= rrun + 1;
            end else begin
                rrun <= 0;
            end
            if (valid[act]) begin
                if (fval < 0) fval <= cyc;
                vrun <= vrun + 1;
                if (vrun + 1 > mvrun) mvrun <= vrun + 1;
            end else begin
                vrun <= 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic cycle_check();
        int   occ_m = 0;
        int   pend_m = 0;
        int   pop_m;
        logic ev, er;
        foreach (mq[k]) begin
            if (mq[k].rc <= cyc) occ_m++;
            else pend_m++;
        end
        ev = (occ_m != 0);
        chk("valid", 32'(valid[act]), 32'(ev));
        if (ev) chk("data", 32'(data[act]), 32'(mq[0].w));
        pop_m = (ev && ready[act]) ? 1 : 0;
        er = srst[act] && (head[act] < n[act]) && (occ_m + pend_m - pop_m < 2);
        chk("rd_req", 32'(rd_req[act]), 32'(er));
        chk("rd_cnt", 32'(cnt_act), 32'(exp_cnt));
    endtask

    always @(negedge clk) if (chk_en) cycle_check();

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic load(input int i, input int nw, output int base);
        base = n[i];
        for (int k = 0; k < nw; k++) begin
            mem[i][n[i]] = 8'($urandom_range(0, 255));
            n[i]++;
        end
    endtask

    task automatic do_reset(input int a);
        chk_en  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            srst[i]  = 1'b0;
            ready[i] = 1'b0;
        end
        mon_clr = 1'b1;
        act     = a;
        step(2);
        mon_clr = 1'b0;
        chk_en  = 1'b1;
    endtask

    task automatic wait_words(input int nw, input int budget);
        int t = 0;
        while (dlog.size() < nw && t < budget) begin
            step(1);
            t++;
        end
        chk("words_delivered", 32'(dlog.size()), 32'(nw));
    endtask

    task automatic check_order(input int base, input int nw);
        for (int k = 0; k < nw && k < dlog.size(); k++)
            chk("order", 32'(dlog[k]), 32'(mem[act][base + k]));
    endtask

    initial begin
        int b, b2, t;
        for (int i = 0; i < 3; i++) begin
            srst[i]  = 1'b0;
            ready[i] = 1'b0;
            for (int k = 0; k < 64; k++) mem[i][k] = 8'h00;
        end
        step(3);

        // reset state
        do_reset(0);
        chk("rst_valid", 32'(valid[0]), 32'd0);
        chk("rst_data", 32'(data[0]), 32'd0);
        chk("rst_cnt", 32'(cnt0), 32'd0);
        chk("rst_req", 32'(rd_req[0]), 32'd0);

        // registered FIFO, streaming
        load(0, 8, b);
        ready[0] = 1'b1;
        srst[0]  = 1'b1;
        wait_words(8, 40);
        check_order(b, 8);
        chk("off_nreq", 32'(nreq), 32'd8);
        chk("off_req_run", 32'(mrrun), 32'd8);
        chk("off_valid_run", 32'(mvrun), 32'd8);
        chk("off_latency", 32'(fval - freq), 32'd2);
        step(1);
        chk("off_cnt", 32'(cnt0), 32'd8);

        // downstream stall for 10 cycles
        do_reset(0);
        load(0, 8, b);
        srst[0] = 1'b1;
        step(10);
        chk("stall_reqs", 32'(nreq), 32'd2);
        chk("stall_valid", 32'(valid[0]), 32'd1);
        chk("stall_data", 32'(data[0]), 32'(mem[0][b]));
        ready[0] = 1'b1;
        wait_words(8, 40);
        check_order(b, 8);
        chk("stall_total_reqs", 32'(nreq), 32'd8);

        // ready toggling every cycle
        do_reset(0);
        load(0, 8, b);
        ready[0] = 1'b1;
        srst[0]  = 1'b1;
        t = 0;
        while (dlog.size() < 8 && t < 100) begin
            step(1);
            ready[0] = ~ready[0];
            t++;
        end
        chk("toggle_words", 32'(dlog.size()), 32'd8);
        check_order(b, 8);

        // reset after three words delivered
        do_reset(0);
        load(0, 8, b);
        ready[0] = 1'b1;
        srst[0]  = 1'b1;
        t = 0;
        while (dlog.size() < 3 && t < 40) begin
            step(1);
            t++;
        end
        chk("mid_three", 32'(dlog.size()), 32'd3);
        srst[0] = 1'b0;
        mon_clr = 1'b1;
        step(1);
        srst[0] = 1'b1;
        mon_clr = 1'b0;
        chk("mid_valid", 32'(valid[0]), 32'd0);
        chk("mid_cnt", 32'(cnt0), 32'd0);
        chk("mid_data", 32'(data[0]), 32'd0);
        b2 = head[0];
        chk("mid_head", 32'(b2), 32'(b + 5));
        wait_words(3, 40);
        check_order(b2, 3);

        // show-ahead FIFO
        do_reset(1);
        load(1, 8, b);
        ready[1] = 1'b1;
        srst[1]  = 1'b1;
        wait_words(8, 40);
        check_order(b, 8);
        chk("on_nreq", 32'(nreq), 32'd8);
        chk("on_req_run", 32'(mrrun), 32'd8);
        chk("on_valid_run", 32'(mvrun), 32'd8);
        chk("on_latency", 32'(fval - freq), 32'd1);
        step(1);
        chk("on_cnt", 32'(cnt1), 32'd8);

        // 4-bit counter wrap after 20 words
        do_reset(2);
        load(2, 20, b);
        ready[2] = 1'b1;
        srst[2]  = 1'b1;
        wait_words(20, 80);
        check_order(b, 20);
        step(1);
        chk("wrap_cnt", 32'(cnt2), 32'd4);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
